line_clear_engine: RTL

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

---
 rtl/line_clear_engine_pkg.sv | 19 +
 rtl/line_clear_engine_row_full_detect.sv | 20 ++
 rtl/line_clear_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/line_clear_engine_pkg.sv
// Shared types for the line clear engine.
// Cell colours and default board dimensions.
package line_clear_engine_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        CYAN   = 3'd1,
        BLUE   = 3'd2,
        ORANGE = 3'd3,
        YELLOW = 3'd4,
        GREEN  = 3'd5,
        PURPLE = 3'd6,
        RED    = 3'd7
    } block_color;

    localparam int X_SIZE_DEF = 10;
    localparam int Y_SIZE_DEF = 20;

endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// Flags a board row whose cells are all occupied.
// Purely combinational.
module row_full_detect
    import line_clear_engine_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF
) (
    input  block_color row [X_SIZE],
    output logic       full
);

    // A single empty cell makes the row non-full
    always_comb begin
        full = 1'b1;
        for (int i = 0; i < X_SIZE; i++) begin
            if (row[i] == EMPTY) full = 1'b0;
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Removes full rows from a board and drops the rest down.
// One row is scanned per cycle, then freed rows are blanked.
module line_clear_engine
    import line_clear_engine_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int CNT_W  = $clog2(Y_SIZE + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  block_color       board_in  [X_SIZE][Y_SIZE],
    output block_color       board_out [X_SIZE][Y_SIZE],
    output logic [CNT_W-1:0] num_lines,
    output logic             busy,
    output logic             done
);

    localparam int RW = $clog2(Y_SIZE);
    localparam logic [RW-1:0] LAST = RW'(Y_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FILL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    block_color       board   [X_SIZE][Y_SIZE];
    block_color       cur_row [X_SIZE];
    logic [RW-1:0]    rd;
    logic [RW-1:0]    wr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             accept;

    // A start coinciding with the done pulse is not a new request
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    // Present the row under the read pointer to the detector
    always_comb begin
        for (int c = 0; c < X_SIZE; c++) cur_row[c] = board[c][rd];
    end

    row_full_detect #(
        .X_SIZE(X_SIZE)
    ) u_full (
        .row (cur_row),
        .full(full)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; FILL is skipped when nothing was removed
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = SCAN;
            SCAN: begin
                if (rd == '0) begin
                    if (cnt != '0 || full) state_nxt = FILL;
                    else                   state_nxt = DONE;
                end
            end
            FILL: if (wr == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
        endcase
    end

    // Board compaction datapath and result registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int c = 0; c < X_SIZE; c++) begin
                for (int y = 0; y < Y_SIZE; y++) begin
                    board[c][y]     <= EMPTY;
                    board_out[c][y] <= EMPTY;
                end
            end
            rd        <= '0;
            wr        <= '0;
            cnt       <= '0;
            num_lines <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        board <= board_in;
                        rd    <= LAST;
                        wr    <= LAST;
                        cnt   <= '0;
                    end
                end
                SCAN: begin
                    if (full) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        for (int c = 0; c < X_SIZE; c++) begin
                            board[c][wr] <= board[c][rd];
                        end
                        if (wr != '0) wr <= wr - RW'(1);
                    end
                    if (rd != '0) rd <= rd - RW'(1);
                end
                FILL: begin
                    for (int c = 0; c < X_SIZE; c++) board[c][wr] <= EMPTY;
                    if (wr != '0) wr <= wr - RW'(1);
                end
                DONE: begin
                    board_out <= board;
                    num_lines <= cnt;
                    done      <= 1'b1;
                end
            endcase
        end
    end

endmodule
